// File: rtl/model_trainer_stream_sequencer_pkg.sv
// Shared types and helpers for the trainer stream sequencer.
package model_trainer_stream_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Width of a channel pointer; never narrower than one bit.
   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/model_trainer_stream_sequencer_if.sv
// Control, source and destination signals of the trainer stream sequencer.
interface model_trainer_stream_sequencer_if #(
   parameter int DATA_SIZE   = 64,
   parameter int CHANNELS    = 4,
   parameter int COUNT_WIDTH = 16
);
   logic                            START;
   logic                            ABORT;
   logic                            MODE;
   logic                            READY;
   logic [CHANNELS*COUNT_WIDTH-1:0] SIZE_IN;
   logic [DATA_SIZE-1:0]            DATA_IN;
   logic                            DATA_IN_VALID;
   logic                            DATA_IN_READY;
   logic [DATA_SIZE-1:0]            DATA_OUT;
   logic [CHANNELS-1:0]             ENABLE_OUT;
   logic [COUNT_WIDTH-1:0]          INDEX_OUT;

   modport master (
      output START, ABORT, MODE, SIZE_IN, DATA_IN, DATA_IN_VALID,
      input  READY, DATA_IN_READY, DATA_OUT, ENABLE_OUT, INDEX_OUT
   );

   modport slave (
      input  START, ABORT, MODE, SIZE_IN, DATA_IN, DATA_IN_VALID,
      output READY, DATA_IN_READY, DATA_OUT, ENABLE_OUT, INDEX_OUT
   );
endinterface

// File: rtl/model_trainer_stream_sequencer_picker.sv
// Combinational search for the next channel that still has elements left.
module model_trainer_stream_picker #(
   parameter int CHANNELS = 4,
   parameter int IW       = 2
) (
   input  logic [CHANNELS-1:0] mask,
   input  logic [IW-1:0]       ptr,
   input  logic                mode,
   output logic [IW-1:0]       next,
   output logic                any
);

   localparam logic [IW:0] CH = (IW+1)'(CHANNELS);

   logic [IW:0] cand;
   logic        found;

   // Mode 0 may stay on ptr (offset 0); mode 1 starts one past ptr and
   // only reaches ptr again at offset CHANNELS, after every other channel.
   always_comb begin
      next  = '0;
      found = 1'b0;
      cand  = '0;
      any   = |mask;
      for (int off = 0; off <= CHANNELS; off++) begin
         cand = {1'b0, ptr} + (IW+1)'(off);
         if (cand >= CH) cand = cand - CH;
         if (!found && !(mode && (off == 0)) && mask[cand[IW-1:0]]) begin
            found = 1'b1;
            next  = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/model_trainer_stream_sequencer.sv
// Streams source words to CHANNELS operand channels, sequential or round-robin.
module model_trainer_stream_sequencer
   import model_trainer_stream_pkg::*;
#(
   parameter int DATA_SIZE   = 64,
   parameter int CHANNELS    = 4,
   parameter int COUNT_WIDTH = 16
) (
   input logic                            CLK,
   input logic                            RST,
   model_trainer_stream_sequencer_if.slave bus
);

   localparam int                  IW       = ch_idx_w(CHANNELS);
   localparam logic [CHANNELS-1:0] ONE_HOT0 = CHANNELS'(1);

   state_t state, state_n;

   logic [COUNT_WIDTH-1:0] remaining [CHANNELS];
   logic [COUNT_WIDTH-1:0] index     [CHANNELS];
   logic [IW-1:0]          ptr;
   logic                   mode_r;

   logic [CHANNELS-1:0]    size_nz;
   logic [CHANNELS-1:0]    left_nz;
   logic [IW-1:0]          init_ptr;
   logic [IW-1:0]          next_ptr;
   logic                   init_any;
   logic                   next_any;

   logic                   ready;
   logic                   in_ready;
   logic                   start_go;
   logic                   accept;
   logic                   abort_go;

   logic [DATA_SIZE-1:0]   data_r;
   logic [CHANNELS-1:0]    enable_r;
   logic [COUNT_WIDTH-1:0] index_r;

   // left_nz is the nonempty mask as it will look after the current accept.
   always_comb begin
      size_nz = '0;
      left_nz = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         size_nz[c] = |bus.SIZE_IN[c*COUNT_WIDTH +: COUNT_WIDTH];
         left_nz[c] = (IW'(c) == ptr) ? (remaining[c] > COUNT_WIDTH'(1))
                                      : (remaining[c] != '0);
      end
   end

   model_trainer_stream_picker #(
      .CHANNELS (CHANNELS),
      .IW       (IW)
   ) u_init_pick (
      .mask (size_nz),
      .ptr  (IW'(CHANNELS-1)),
      .mode (1'b1),
      .next (init_ptr),
      .any  (init_any)
   );

   model_trainer_stream_picker #(
      .CHANNELS (CHANNELS),
      .IW       (IW)
   ) u_next_pick (
      .mask (left_nz),
      .ptr  (ptr),
      .mode (mode_r),
      .next (next_ptr),
      .any  (next_any)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n  = state;
      ready    = 1'b0;
      in_ready = 1'b0;
      start_go = 1'b0;
      accept   = 1'b0;
      abort_go = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (bus.START) begin
               start_go = 1'b1;
               state_n  = init_any ? STREAM : DONE;
            end
         end
         STREAM: begin
            if (bus.ABORT) begin
               abort_go = 1'b1;
               state_n  = IDLE;
            end else begin
               in_ready = 1'b1;
               if (bus.DATA_IN_VALID) begin
                  accept = 1'b1;
                  if (!next_any) state_n = DONE;
               end
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign bus.READY         = ready;
   assign bus.DATA_IN_READY = in_ready;
   assign bus.DATA_OUT      = data_r;
   assign bus.ENABLE_OUT    = enable_r;
   assign bus.INDEX_OUT     = index_r;

   // ---- output register stage: strobe follows its accept by one cycle ----
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int c = 0; c < CHANNELS; c++) begin
            remaining[c] <= '0;
            index[c]     <= '0;
         end
         ptr      <= '0;
         mode_r   <= 1'b0;
         data_r   <= '0;
         enable_r <= '0;
         index_r  <= '0;
      end else begin
         enable_r <= '0;
         if (start_go) begin
            for (int c = 0; c < CHANNELS; c++) begin
               remaining[c] <= bus.SIZE_IN[c*COUNT_WIDTH +: COUNT_WIDTH];
               index[c]     <= '0;
            end
            ptr    <= init_ptr;
            mode_r <= bus.MODE;
         end
         if (abort_go) begin
            for (int c = 0; c < CHANNELS; c++) remaining[c] <= '0;
         end
         if (accept) begin
            data_r         <= bus.DATA_IN;
            enable_r       <= ONE_HOT0 << ptr;
            index_r        <= index[ptr];
            remaining[ptr] <= remaining[ptr] - COUNT_WIDTH'(1);
            index[ptr]     <= index[ptr] + COUNT_WIDTH'(1);
            ptr            <= next_ptr;
         end
      end
   end

endmodule

// File: tb/tb_model_trainer_stream_sequencer.sv
// Scoreboard bench for the trainer stream sequencer with directed vectors.
module tb_model_trainer_stream_sequencer;

   localparam int DW = 64;
   localparam int CH = 4;
   localparam int CW = 8;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   model_trainer_stream_sequencer_if #(
      .DATA_SIZE(DW), .CHANNELS(CH), .COUNT_WIDTH(CW)
   ) bus ();

   model_trainer_stream_sequencer #(
      .DATA_SIZE(DW), .CHANNELS(CH), .COUNT_WIDTH(CW)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [CH-1:0] en;
      logic [CW-1:0] idx;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc_cnt  = 0;

   // sizes {ch3=1, ch2=3, ch1=0, ch0=2}
   localparam logic [CH*CW-1:0] SIZES = {8'd1, 8'd3, 8'd0, 8'd2};

   logic [CH-1:0] seq_en [6] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
   int            seq_idx[6] = '{0, 1, 0, 1, 2, 0};
   logic [CH-1:0] rr_en  [6] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b0100};
   int            rr_idx [6] = '{0, 0, 0, 1, 1, 2};

   always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic queue_exp(input bit rr, input int n);
      for (int k = 0; k < n; k++) begin
         exp_t e;
         e.en   = rr ? rr_en[k] : seq_en[k];
         e.idx  = CW'(rr ? rr_idx[k] : seq_idx[k]);
         e.data = DW'(k + 1);
         exp_q.push_back(e);
      end
   endtask

   // Monitor: every strobe must match the head of the scoreboard and
   // appear in the cycle right after its accept.
   always @(negedge CLK) begin
      if (bus.ENABLE_OUT != '0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 64'(bus.ENABLE_OUT), 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("enable_out", 64'(bus.ENABLE_OUT), 64'(mon_e.en));
            check("index_out",  64'(bus.INDEX_OUT),  64'(mon_e.idx));
            check("data_out",   bus.DATA_OUT,        mon_e.data);
         end
         if (acc_q.size() == 0) check("strobe_without_accept", 64'(cyc_cnt), 64'd0);
         else                   check("strobe_latency", 64'(cyc_cnt), 64'(acc_q.pop_front()));
      end
   end

   task automatic start_seq(input logic [CH*CW-1:0] sizes, input logic mode);
      bus.SIZE_IN = sizes;
      bus.MODE    = mode;
      bus.START   = 1'b1;
      @(posedge CLK); #1;
      bus.START = 1'b0;
      check("ready_fall", 64'(bus.READY), 64'd0);
   endtask

   task automatic feed(input int n, input bit alt, input int abort_at, input int exp_cycles);
      int sent = 0;
      int it   = 0;
      bit acc;
      while (sent < n && it < 100) begin
         if (abort_at >= 0 && sent == abort_at) begin
            bus.ABORT         = 1'b1;
            bus.DATA_IN_VALID = 1'b1;
            bus.DATA_IN       = DW'(sent + 1);
            #1;
            check("in_ready_during_abort", 64'(bus.DATA_IN_READY), 64'd0);
            @(posedge CLK); #1;
            bus.ABORT         = 1'b0;
            bus.DATA_IN_VALID = 1'b0;
            check("ready_after_abort", 64'(bus.READY), 64'd1);
            it++;
            break;
         end
         bus.DATA_IN_VALID = alt ? (it % 2 == 0) : 1'b1;
         bus.DATA_IN       = DW'(sent + 1);
         @(negedge CLK);
         acc = bus.DATA_IN_VALID && bus.DATA_IN_READY;
         @(posedge CLK); #1;
         if (acc) begin
            sent++;
            acc_q.push_back(cyc_cnt);
         end
         it++;
      end
      bus.DATA_IN_VALID = 1'b0;
      check("feed_cycles", 64'(it), 64'(exp_cycles));
   endtask

   task automatic finish_seq();
      check("ready_in_done", 64'(bus.READY), 64'd0);
      @(posedge CLK); #1;
      check("ready_rise", 64'(bus.READY), 64'd1);
   endtask

   task automatic drain(input string name);
      repeat (2) @(posedge CLK);
      #1;
      check(name, 64'(exp_q.size() + acc_q.size()), 64'd0);
   endtask

   initial begin
      bus.START = 1'b0; bus.ABORT = 1'b0; bus.MODE = 1'b0;
      bus.SIZE_IN = '0; bus.DATA_IN = '0; bus.DATA_IN_VALID = 1'b0;

      @(posedge CLK); #1;
      check("rst_ready",    64'(bus.READY),         64'd1);
      check("rst_in_ready", 64'(bus.DATA_IN_READY), 64'd0);
      check("rst_enable",   64'(bus.ENABLE_OUT),    64'd0);
      check("rst_data",     bus.DATA_OUT,           64'd0);
      check("rst_index",    64'(bus.INDEX_OUT),     64'd0);
      RST = 1'b1;
      @(posedge CLK); #1;

      // sequential, source always valid
      queue_exp(1'b0, 6);
      start_seq(SIZES, 1'b0);
      feed(6, 1'b0, -1, 6);
      finish_seq();
      drain("drain_seq");

      // round-robin, source always valid
      queue_exp(1'b1, 6);
      start_seq(SIZES, 1'b1);
      feed(6, 1'b0, -1, 6);
      finish_seq();
      drain("drain_rr");

      // sequential, source valid every other cycle
      queue_exp(1'b0, 6);
      start_seq(SIZES, 1'b0);
      feed(6, 1'b1, -1, 11);
      finish_seq();
      drain("drain_alt");

      // all sizes zero
      bus.DATA_IN_VALID = 1'b1;
      start_seq('0, 1'b0);
      check("zero_in_ready_done", 64'(bus.DATA_IN_READY), 64'd0);
      @(posedge CLK); #1;
      check("zero_ready_back", 64'(bus.READY), 64'd1);
      check("zero_in_ready_idle", 64'(bus.DATA_IN_READY), 64'd0);
      bus.DATA_IN_VALID = 1'b0;
      drain("drain_zero");

      // abort after two accepts, then replay from scratch
      queue_exp(1'b0, 2);
      start_seq(SIZES, 1'b0);
      feed(6, 1'b0, 2, 3);
      drain("drain_abort");
      queue_exp(1'b0, 6);
      start_seq(SIZES, 1'b0);
      feed(6, 1'b0, -1, 6);
      finish_seq();
      drain("drain_replay");

      // asynchronous reset mid-stream, then a full run
      start_seq(SIZES, 1'b0);
      bus.DATA_IN_VALID = 1'b1;
      bus.DATA_IN       = DW'(1);
      @(posedge CLK); #1;
      RST = 1'b0;
      #1;
      check("arst_ready",    64'(bus.READY),         64'd1);
      check("arst_in_ready", 64'(bus.DATA_IN_READY), 64'd0);
      check("arst_enable",   64'(bus.ENABLE_OUT),    64'd0);
      check("arst_data",     bus.DATA_OUT,           64'd0);
      check("arst_index",    64'(bus.INDEX_OUT),     64'd0);
      bus.DATA_IN_VALID = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      queue_exp(1'b0, 6);
      start_seq(SIZES, 1'b0);
      feed(6, 1'b0, -1, 6);
      finish_seq();
      drain("drain_after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/model_trainer_stream_sequencer.md
# model_trainer_stream_sequencer

Parametrised, synthesizable stream sequencer that feeds tensor operands into the NTM trainer datapaths (LSTM and successors). It supersedes the fixed per-operand enable wiring with a generic CHANNELS-wide engine. On START it latches a programmable element count per channel and pulls words from a valid/ready source. Each word is re-emitted with a one-hot per-channel enable strobe and its element index, in sequential or round-robin interleaved order.

## Interface
- DATA_SIZE, 64, data word width
- CHANNELS, 4, number of destination operand channels (>=1)
- COUNT_WIDTH, 16, width of per-channel element counts and indices
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- START  in  1  begin sequence; sampled only in IDLE
- ABORT  in  1  synchronous cancel; effective only in STREAM
- MODE  in  1  0 = sequential (channel by channel), 1 = interleaved round-robin
- READY  out  1  high iff FSM in IDLE
- SIZE_IN  in  CHANNELS*COUNT_WIDTH  element count per channel, channel c at [c*COUNT_WIDTH +: COUNT_WIDTH]; 0 = skip channel
- DATA_IN  in  DATA_SIZE  source word
- DATA_IN_VALID  in  1  source word valid
- DATA_IN_READY  out  1  sequencer accepts word
- DATA_OUT  out  DATA_SIZE  registered word
- ENABLE_OUT  out  CHANNELS  one-hot single-cycle strobe qualifying DATA_OUT
- INDEX_OUT  out  COUNT_WIDTH  element index of DATA_OUT within its channel, 0-based

## Operation
- States: IDLE, STREAM, DONE.
- IDLE: START=1 latches SIZE_IN into remaining[c]; clears index[c]; selects the lowest channel with nonzero size as pointer. Goes to STREAM, or to DONE if all sizes are 0. START outside IDLE is ignored.
- STREAM: DATA_IN_READY = ~ABORT. An accept (VALID & READY) registers DATA_IN, one-hot(pointer), index[pointer]; decrements remaining[pointer]; increments index[pointer].
- Next pointer after accept:
  - MODE=0: stays on the current channel while remaining>0 after decrement, else moves to the next higher channel with remaining>0.
  - MODE=1: moves to the next channel after the pointer (wrapping) with remaining>0, including the pointer itself if it is the only one left.
- Last accept (no channel remains) -> DONE.
- ABORT in STREAM -> IDLE; no accept that cycle; remaining cleared.
- DONE: unconditional -> IDLE.
- MODE is sampled with START and held for the sequence.
- Counts are unsigned; no wrap: a channel never emits more than SIZE_IN words.

## Timing
- Reset (RST=0) values:
  - FSM IDLE, READY=1.
  - DATA_IN_READY=0, ENABLE_OUT=0, DATA_OUT=0, INDEX_OUT=0.
  - Counters 0.
- Output latency: 1 cycle from accept edge to ENABLE_OUT/DATA_OUT/INDEX_OUT valid. ENABLE_OUT is high exactly one cycle per accept.
- Full throughput: one word per cycle while DATA_IN_VALID=1, in both modes. Channel switches cost no bubble.
- READY falls the cycle after START is sampled.
- After the last accept, ENABLE_OUT fires in the DONE cycle; READY rises the following cycle.
- All-zero sizes: READY low for exactly one cycle, no ENABLE_OUT.
- ABORT: the strobe from an accept in the previous cycle is still emitted. READY is high the cycle after ABORT.
- RST asserted mid-stream clears everything asynchronously. The next START restarts all channels at index 0.

## Structure
- Package model_trainer_stream_pkg:
  - state enum (IDLE, STREAM, DONE)
  - channel-index width function, clog2 with minimum 1
- Sub-module model_trainer_stream_picker: combinational next-channel search. Inputs are a nonempty mask, the pointer and MODE; outputs are the next index and an any-left flag. Reused for initial selection with pointer = CHANNELS-1 and MODE=1.

## Test plan
- CHANNELS=4, COUNT_WIDTH=8, sizes {ch0=2, ch1=0, ch2=3, ch3=1}, MODE=0, source always valid, data 1..6 -> ENABLE_OUT 0001,0001,0100,0100,0100,1000; INDEX_OUT 0,1,0,1,2,0; DATA_OUT 1..6; READY rises 1 cycle after the last strobe.
- Same sizes, MODE=1 -> channel order 0,2,3,0,2,2; INDEX_OUT 0,0,0,1,1,2; no bubbles (6 consecutive strobes).
- Same as first case, DATA_IN_VALID alternating 1,0 -> exactly 6 strobes, each one cycle after its accept; no duplicates; order unchanged.
- All sizes 0, START -> READY low exactly one cycle, ENABLE_OUT never asserted, DATA_IN_READY never asserted.
- First case, ABORT pulsed after 2 accepts -> DATA_IN_READY=0 in the ABORT cycle; exactly 2 strobes total; READY=1 next cycle. A new START replays from channel 0, index 0.
- RST driven low mid-STREAM -> outputs zero and READY=1 without a clock edge; after release, START runs the full first-case sequence correctly.
